// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off events onto NUM_VOICES synth voice slots
// and drives the per-voice active mask, note numbers and restart pulses.
// Latency: an event accepted at edge E0 updates the outputs at E2, so one event
//   is taken every 3 cycles.
// Backpressure: note_ready is low outside IDLE, while all_off is high, and in reset.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   note_valid/ready     event handshake; note_on selects on/off, note_num the key
//   all_off              panic release of every voice, honoured only in IDLE
//   in_use               per-voice active mask
//   voice_notes          voice i note in bits [i*NOTE_W +: NOTE_W]
//   voice_start, stolen  one-cycle pulses for (re)trigger and eviction
module voice_allocator #(
  parameter int NUM_VOICES = 10,
  parameter int NOTE_W     = 7,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic                         note_on,
  input  logic [NOTE_W-1:0]            note_num,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        in_use,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_notes,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic                         stolen
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_APPLY} state_t;

  state_t                  r_state;
  logic                    r_on;
  logic [NOTE_W-1:0]       r_num;
  logic [NUM_VOICES-1:0]   r_in_use;
  logic [NOTE_W-1:0]       r_notes [NUM_VOICES];
  logic [AGE_W-1:0]        r_age   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_start;
  logic                    r_stolen;

  // Search results captured in SEARCH and consumed in APPLY.
  logic [NUM_VOICES-1:0]   r_match;
  logic                    r_has_match;
  logic                    r_has_free;
  logic [IDX_W-1:0]        r_match_idx;
  logic [IDX_W-1:0]        r_free_idx;
  logic [IDX_W-1:0]        r_old_idx;

  logic [NUM_VOICES-1:0]   w_match;
  logic                    w_has_match;
  logic                    w_has_free;
  logic [IDX_W-1:0]        w_match_idx;
  logic [IDX_W-1:0]        w_free_idx;
  logic [IDX_W-1:0]        w_old_idx;
  logic [AGE_W-1:0]        w_old_age;
  logic [IDX_W-1:0]        w_sel;

  assign note_ready = (r_state == S_IDLE) && !reset && !all_off;

  always_comb begin
    w_match     = '0;
    w_has_match = 1'b0;
    w_match_idx = '0;
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    // Walking downwards lets the lowest index be the last (winning) write.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_in_use[i] && (r_notes[i] == r_num)) begin
        w_match[i]  = 1'b1;
        w_has_match = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_in_use[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    // Strictly-greater compare keeps the lowest index on age ties.
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = IDX_W'(i);
      end
    end
  end

  // Priority: retrigger an existing holder, else a free slot, else the oldest.
  assign w_sel = r_has_match ? r_match_idx : (r_has_free ? r_free_idx : r_old_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_on        <= 1'b0;
      r_num       <= '0;
      r_in_use    <= '0;
      r_start     <= '0;
      r_stolen    <= 1'b0;
      r_match     <= '0;
      r_has_match <= 1'b0;
      r_has_free  <= 1'b0;
      r_match_idx <= '0;
      r_free_idx  <= '0;
      r_old_idx   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_notes[i] <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      r_start  <= '0;
      r_stolen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (all_off) begin
            r_in_use <= '0;
            for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
          end else if (note_valid) begin
            r_on    <= note_on;
            r_num   <= note_num;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_match     <= w_match;
          r_has_match <= w_has_match;
          r_has_free  <= w_has_free;
          r_match_idx <= w_match_idx;
          r_free_idx  <= w_free_idx;
          r_old_idx   <= w_old_idx;
          r_state     <= S_APPLY;
        end
        S_APPLY: begin
          r_state <= S_IDLE;
          if (r_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == w_sel) begin
                r_in_use[i] <= 1'b1;
                r_notes[i]  <= r_num;
                r_age[i]    <= '0;
                r_start[i]  <= 1'b1;
              end else if (r_in_use[i] && (r_age[i] != {AGE_W{1'b1}})) begin
                r_age[i] <= r_age[i] + 1'b1;
              end
            end
            r_stolen <= !r_has_match && !r_has_free;
          end else begin
            // Released voices keep their note but drop back to age 0.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_match[i]) begin
                r_in_use[i] <= 1'b0;
                r_age[i]    <= '0;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_use      = r_in_use;
  assign voice_start = r_start;
  assign stolen      = r_stolen;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_notes
    assign voice_notes[g*NOTE_W +: NOTE_W] = r_notes[g];
  end

endmodule
